// File: rtl/block_fifo_pkg.sv
// Shared defaults and width helper for the block FIFO.
// The optional sticky error flags are enabled by defining BLOCK_FIFO_ERR_FLAGS_EN.
package block_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  // Occupancy needs one extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/block_fifo_mem.sv
// Storage array for block_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module block_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/block_fifo.sv
// Show-ahead synchronous FIFO with burst-threshold wait indications.
// Define BLOCK_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flag registers.
module block_fifo
  import block_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic [CNT_W-1:0]  block_size,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              wait_in,
  output logic              wait_out,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   free_words;
  logic             push_ok;
  logic             pop_ok;

  // Handshake: a push is taken on a rising edge when push=1 and full=0; a pop is taken when
  // pop=1 and empty=0. There is no back-pressure beyond full/empty, and clear overrides both.
  assign push_ok = push && !full  && !clear;
  assign pop_ok  = pop  && !empty && !clear;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Free space is formed one bit wider so DEPTH - count never wraps before the compare.
  assign free_words = DEPTH_X - {1'b0, count_q};
  assign wait_in    = free_words < {1'b0, block_size};
  assign wait_out   = count_q < block_size;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  block_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (dout)
  );

`ifdef BLOCK_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Flags record any rejected request and hold until clear or reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full)  overflow_q  <= 1'b1;
      if (pop  && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_block_fifo.sv
// Self-checking bench for block_fifo: a DEPTH=16 instance for directed/random work and a
// DEPTH=8 instance for pointer-wrap ordering, both checked against queue-based models.
module tb_block_fifo;

`ifdef BLOCK_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DEPTH=16 instance ----------------
  logic        clear16 = 0, push16 = 0, pop16 = 0;
  logic [31:0] din16 = '0;
  logic [4:0]  bs16 = 5'd4;
  logic [31:0] dout16;
  logic        full16, empty16, wait_in16, wait_out16, ovf16, unf16;
  logic [4:0]  count16;

  block_fifo #(.DATA_W(32), .DEPTH(16)) dut16 (
    .clock(clock), .reset(reset), .clear(clear16), .push(push16), .pop(pop16),
    .din(din16), .block_size(bs16), .dout(dout16), .full(full16), .empty(empty16),
    .count(count16), .wait_in(wait_in16), .wait_out(wait_out16),
    .overflow(ovf16), .underflow(unf16)
  );

  // ---------------- DEPTH=8 instance ----------------
  logic        clear8 = 0, push8 = 0, pop8 = 0;
  logic [15:0] din8 = '0;
  logic [3:0]  bs8 = 4'd2;
  logic [15:0] dout8;
  logic        full8, empty8, wait_in8, wait_out8, ovf8, unf8;
  logic [3:0]  count8;

  block_fifo #(.DATA_W(16), .DEPTH(8)) dut8 (
    .clock(clock), .reset(reset), .clear(clear8), .push(push8), .pop(pop8),
    .din(din8), .block_size(bs8), .dout(dout8), .full(full8), .empty(empty8),
    .count(count8), .wait_in(wait_in8), .wait_out(wait_out8),
    .overflow(ovf8), .underflow(unf8)
  );

  // ---------------- reference models ----------------
  logic [31:0] exp_q[$];
  logic [15:0] exp_q8[$];
  bit          m_ovf, m_unf, m_ovf8, m_unf8;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge for the 16-deep FIFO, from the current input values.
  task automatic model16();
    bit do_push, do_pop;
    if (clear16) begin
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      do_push = push16 && (exp_q.size() < 16);
      do_pop  = pop16 && (exp_q.size() > 0);
      if (ERR_EN && push16 && !do_push) m_ovf = 1;
      if (ERR_EN && pop16 && exp_q.size() == 0) m_unf = 1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(din16);
    end
  endtask

  task automatic model8();
    bit do_push, do_pop;
    do_push = push8 && (exp_q8.size() < 8);
    do_pop  = pop8 && (exp_q8.size() > 0);
    if (ERR_EN && push8 && !do_push) m_ovf8 = 1;
    if (ERR_EN && pop8 && exp_q8.size() == 0) m_unf8 = 1;
    if (do_pop) void'(exp_q8.pop_front());
    if (do_push) exp_q8.push_back(din8);
  endtask

  task automatic check16(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, "_count"}, count16, sz);
    chk({tag, "_empty"}, empty16, sz == 0);
    chk({tag, "_full"}, full16, sz == 16);
    chk({tag, "_wait_in"}, wait_in16, (16 - sz) < int'(bs16));
    chk({tag, "_wait_out"}, wait_out16, sz < int'(bs16));
    chk({tag, "_ovf"}, ovf16, m_ovf);
    chk({tag, "_unf"}, unf16, m_unf);
    if (sz > 0) chk({tag, "_dout"}, dout16, exp_q[0]);
  endtask

  task automatic check8(input string tag);
    int sz;
    sz = exp_q8.size();
    chk({tag, "_count"}, count8, sz);
    chk({tag, "_full"}, full8, sz == 8);
    chk({tag, "_empty"}, empty8, sz == 0);
    chk({tag, "_wait_in"}, wait_in8, (8 - sz) < int'(bs8));
    chk({tag, "_wait_out"}, wait_out8, sz < int'(bs8));
    chk({tag, "_ovf"}, ovf8, m_ovf8);
    chk({tag, "_unf"}, unf8, m_unf8);
    if (sz > 0) chk({tag, "_dout"}, dout8, exp_q8[0]);
  endtask

  // Apply the current inputs on the next rising edge and settle 1 time unit after it.
  task automatic step16(input string tag);
    model16();
    @(posedge clock);
    #1;
    check16(tag);
  endtask

  task automatic drive16(input logic p, input logic q, input logic [31:0] d, input string tag);
    push16 = p;
    pop16  = q;
    din16  = d;
    step16(tag);
    push16 = 0;
    pop16  = 0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check16("reset");
    check8("reset8");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Fill 0..15; count 11->12->13 crosses wait_in at block_size=4, count 3->4 clears wait_out.
    for (int i = 0; i < 16; i++) begin
      drive16(1, 0, 32'(i), "fill");
      if (i == 3)  chk("wait_out_at4", wait_out16, 1'b0);
      if (i == 11) chk("wait_in_at12", wait_in16, 1'b0);
      if (i == 12) chk("wait_in_at13", wait_in16, 1'b1);
    end
    chk("full_after_fill", full16, 1'b1);
    chk("count_after_fill", count16, 5'd16);

    drive16(1, 0, 32'hDEAD_BEEF, "push17");
    chk("overflow_17th", ovf16, ERR_EN);

    // Drain: show-ahead dout must present 0..15 before each pop.
    for (int i = 0; i < 16; i++) begin
      chk("dout_seq", dout16, 32'(i));
      drive16(0, 1, '0, "drain");
    end
    chk("empty_after_drain", empty16, 1'b1);

    drive16(0, 1, '0, "pop_empty");
    chk("underflow_pop_empty", unf16, ERR_EN);
    chk("count_stays_0", count16, 5'd0);

    drive16(1, 1, 32'h0000_00AA, "pp_empty");
    chk("pp_empty_count", count16, 5'd1);

    for (int i = 0; i < 15; i++) drive16(1, 0, 32'h100 + 32'(i), "refill");
    drive16(1, 1, 32'h0000_0BAD, "pp_full");
    chk("pp_full_count", count16, 5'd15);

    for (int i = 0; i < 10; i++) drive16(0, 1, '0, "to5");
    chk("count_is_5", count16, 5'd5);

    clear16 = 1;
    drive16(1, 0, 32'h0000_0C1E, "clear");
    clear16 = 0;
    chk("clear_count", count16, 5'd0);
    chk("clear_empty", empty16, 1'b1);
    chk("clear_ovf", ovf16, 1'b0);
    chk("clear_unf", unf16, 1'b0);

    // Random traffic with random thresholds (includes 0 and values above DEPTH).
    for (int c = 0; c < 300; c++) begin
      bs16    = 5'($urandom_range(0, 31));
      clear16 = ($urandom_range(0, 40) == 0);
      drive16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rand");
      clear16 = 0;
    end

    // Reset in the middle of a burst: outputs must drop without waiting for an edge.
    bs16 = 5'd4;
    for (int i = 0; i < 6; i++) drive16(1, 0, $urandom, "burst");
    push16 = 1;
    din16  = $urandom;
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 0;
    m_unf = 0;
    exp_q8.delete();
    m_ovf8 = 0;
    m_unf8 = 0;
    check16("async_reset");
    @(posedge clock);
    #1;
    check16("held_reset");
    push16 = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive16(1, 0, 32'h5000 + 32'(i), "post_reset");
    chk("post_reset_head", dout16, 32'h5000);

    // DEPTH=8: 40 pushes interleaved with random pops, crossing the pointer wrap many times.
    for (int i = 0; i < 40; i++) begin
      push8 = 1;
      pop8  = ($urandom_range(0, 3) != 0);
      din8  = 16'($urandom);
      bs8   = 4'($urandom_range(0, 15));
      model8();
      @(posedge clock);
      #1;
      check8("wrap");
    end
    push8 = 0;
    for (int i = 0; i < 9; i++) begin
      pop8 = 1;
      model8();
      @(posedge clock);
      #1;
      check8("wrap_drain");
    end
    pop8 = 0;
    chk("wrap_empty", empty8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
